led_scan_controller: RTL

- Sequencer for the 10-LED scanner display.
- Generates its own prescaled step tick and steps one of four LED patterns, including the 2-wide knight-rider bounce.
- Accepts mode/speed configuration through a valid/ready handshake while idle.
- Sits between the board clock and the LED pins and replaces free-running shift logic with a controlled start/stop sequencer.

---
 rtl/led_scan_pkg.sv | 34 +++
 rtl/led_tick_prescaler.sv | 37 +++
 rtl/led_scan_controller.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/led_scan_pkg.sv
// Shared types for the LED scanner display blocks.
// Holds the configuration mode encoding, the sequencer state set and the
// default number of physical LEDs on the board.
package led_scan_pkg;

  localparam int DEFAULT_NUM_LEDS = 10;

  // Encoding matches the cfg_mode port values.
  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_WRAP   = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOUNCE,
    ST_WRAP,
    ST_FILL,
    ST_BLINK
  } state_e;

  // Active state entered for a given configured mode.
  function automatic state_e mode_to_state(mode_e m);
    case (m)
      MODE_BOUNCE: return ST_BOUNCE;
      MODE_WRAP:   return ST_WRAP;
      MODE_FILL:   return ST_FILL;
      default:     return ST_BLINK;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Step-tick prescaler for display sequencers.
// Counts 0..D-1 with D = max(div, 1) and flags the last count as a tick.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   clear  - holds the count at zero and suppresses tick
//   div    - clocks per tick (0 behaves as 1)
//   tick   - high during the cycle whose count is D-1
module led_tick_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] last;

  // A divide value of zero collapses onto one, so the terminal count is zero.
  assign last = (div == '0) ? '0 : div - 1'b1;
  assign tick = !clear && (count == last);

  // Free-running counter that restarts after each tick or while cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/led_scan_controller.sv
// Start/stop sequencer for the LED scanner display.
// Steps one of four patterns (bounce, wrap-scan, fill/drain, blink) at a
// prescaled rate; mode and divide are configured by handshake while idle.
// Ports:
//   clk, rst_n  - system clock and asynchronous active-low reset
//   cfg_valid   - configuration offer; cfg_ready high only while idle
//   cfg_mode    - 0 bounce, 1 wrap-scan, 2 fill/drain, 3 blink
//   cfg_div     - clocks per pattern step (0 behaves as 1)
//   run         - level: 1 sequences, 0 stops and blanks the LEDs
//   leds        - LED drive, bit 0 leftmost
//   busy        - high in any active state
//   cycle_done  - one-clock pulse at the end of every full pattern period
module led_scan_controller
  import led_scan_pkg::*;
#(
  parameter int NUM_LEDS    = DEFAULT_NUM_LEDS,
  parameter int DIV_W       = 24,
  parameter int DEFAULT_DIV = 5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_mode,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                run,
  output logic [NUM_LEDS-1:0] leds,
  output logic                busy,
  output logic                cycle_done
);

  localparam int POS_W = $clog2(NUM_LEDS + 1);
  localparam logic [POS_W-1:0]    POS_MAX = POS_W'(NUM_LEDS - 2);
  localparam logic [POS_W-1:0]    LVL_MAX = POS_W'(NUM_LEDS);
  localparam logic [NUM_LEDS-1:0] PAIR    = NUM_LEDS'(3);
  localparam logic [NUM_LEDS-1:0] ALL_ON  = '1;

  state_e           state;
  mode_e            mode_q;
  mode_e            entry_mode;
  logic [DIV_W-1:0] div_q;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_nxt;
  logic [POS_W-1:0] level;
  logic [POS_W-1:0] level_nxt;
  logic             dir_down;
  logic             dir_down_nxt;
  logic [NUM_LEDS-1:0] leds_nxt;
  logic             done_nxt;
  logic             accept;
  logic             presc_clear;
  logic             tick;

  assign accept      = cfg_valid && cfg_ready;
  // A configuration accepted on the start edge takes effect immediately.
  assign entry_mode  = accept ? mode_e'(cfg_mode) : mode_q;
  // Holding the prescaler cleared in idle makes the first tick land D clocks after entry.
  assign presc_clear = (state == ST_IDLE);

  led_tick_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (presc_clear),
    .div   (div_q),
    .tick  (tick)
  );

  // Next pattern position and LED image for the current state, applied on a tick.
  always_comb begin
    pos_nxt      = pos;
    level_nxt    = level;
    dir_down_nxt = dir_down;
    leds_nxt     = leds;
    done_nxt     = 1'b0;
    case (state)
      ST_BOUNCE: begin
        if (!dir_down) begin
          if (pos == POS_MAX) begin
            dir_down_nxt = 1'b1;
            pos_nxt      = POS_MAX - 1'b1;
          end else begin
            pos_nxt = pos + 1'b1;
          end
        end else begin
          if (pos == '0) begin
            dir_down_nxt = 1'b0;
            pos_nxt      = POS_W'(1);
          end else begin
            pos_nxt  = pos - 1'b1;
            done_nxt = (pos == POS_W'(1));
          end
        end
        leds_nxt = PAIR << pos_nxt;
      end
      ST_WRAP: begin
        pos_nxt  = (pos == POS_MAX) ? '0 : pos + 1'b1;
        done_nxt = (pos == POS_MAX);
        leds_nxt = PAIR << pos_nxt;
      end
      ST_FILL: begin
        if (!dir_down) begin
          if (level == LVL_MAX) begin
            dir_down_nxt = 1'b1;
            level_nxt    = LVL_MAX - 1'b1;
          end else begin
            level_nxt = level + 1'b1;
          end
        end else begin
          if (level == '0) begin
            dir_down_nxt = 1'b0;
            level_nxt    = POS_W'(1);
          end else begin
            level_nxt = level - 1'b1;
            done_nxt  = (level == POS_W'(1));
          end
        end
        // Thermometer: the low level_nxt bits set.
        leds_nxt = ~(ALL_ON << level_nxt);
      end
      ST_BLINK: begin
        leds_nxt = ~leds;
        done_nxt = (leds == '0);
      end
      default: begin
      end
    endcase
  end

  // Sequencer state, configuration registers and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_BOUNCE;
      div_q      <= DIV_W'(DEFAULT_DIV);
      pos        <= '0;
      level      <= '0;
      dir_down   <= 1'b0;
      leds       <= '0;
      busy       <= 1'b0;
      cfg_ready  <= 1'b1;
      cycle_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cycle_done <= 1'b0;
          if (accept) begin
            mode_q <= mode_e'(cfg_mode);
            div_q  <= cfg_div;
          end
          if (run) begin
            state     <= mode_to_state(entry_mode);
            pos       <= '0;
            level     <= '0;
            dir_down  <= 1'b0;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
            case (entry_mode)
              MODE_BOUNCE, MODE_WRAP: leds <= PAIR;
              MODE_FILL:              leds <= '0;
              default:                leds <= ALL_ON;
            endcase
          end
        end
        default: begin
          if (!run) begin
            // Stop wins over any tick on the same edge, so no pulse is raised.
            state      <= ST_IDLE;
            leds       <= '0;
            busy       <= 1'b0;
            cfg_ready  <= 1'b1;
            cycle_done <= 1'b0;
          end else begin
            cycle_done <= tick && done_nxt;
            if (tick) begin
              pos      <= pos_nxt;
              level    <= level_nxt;
              dir_down <= dir_down_nxt;
              leds     <= leds_nxt;
            end
          end
        end
      endcase
    end
  end

endmodule
